// File: rtl/btb_pkg.sv
// Shared BTB types: parametrised entry struct macro, FSM state enum, saturating counter helpers.
`ifndef BTB_PKG_SV
`define BTB_PKG_SV

`define BTB_ENTRY_T(TW, CW, PW) struct packed { \
  logic [(TW)-1:0] tag;    \
  logic            valid;  \
  logic [(CW)-1:0] ctr;    \
  logic [(PW)-1:0] target; \
}

package btb_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} btb_state_t;

  // Width-generic saturating helpers; w=32 gives a full 32-bit saturating count.
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input int w);
    logic [31:0] mx;
    mx = (32'd1 << w) - 32'd1;
    return (c >= mx) ? mx : c + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] c);
    return (c == 32'd0) ? 32'd0 : c - 32'd1;
  endfunction

endpackage

`endif

// File: rtl/btb_ram.sv
// BTB storage: one write port, one registered read port (lookup), one async read port (update RMW).
module btb_ram #(
  parameter int AW = 9,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [W-1:0]  ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [W-1:0]  rb_data
);

  logic [W-1:0] mem [2**AW];

  // Lookup read samples the pre-write contents, so same-cycle lookups see old data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    ra_data <= mem[ra_addr];
  end

  assign rb_data = mem[rb_addr];

endmodule

// File: rtl/btb_param.sv
// Direct-mapped BTB with init/flush sweep, RMW direction-counter updates and mispredict flag.
// Define BTB_STATS_EN to build the 32-bit saturating branch/hit/mispredict counters.
module btb_param
  import btb_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int IDX_W = 9,
  parameter int CTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            lookup_en,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic            ready,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  output logic            upd_mispredict,
  output logic [31:0]     br_cnt,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int TAG_W = PC_W - IDX_W;

  typedef `BTB_ENTRY_T(TAG_W, CTR_W, PC_W) entry_t;
  localparam int ENT_W = $bits(entry_t);

  btb_state_t       state;
  logic [IDX_W-1:0] sweep_idx;
  logic             lk_vld;
  logic [TAG_W-1:0] lk_tag;

  logic [ENT_W-1:0] ra_raw, rb_raw, wdata;
  entry_t           rd_a, rd_b, nxt;
  logic             upd_we, upd_hit, we;
  logic [IDX_W-1:0] upd_idx, waddr;
  logic [TAG_W-1:0] upd_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      sweep_idx <= '0;
    end else if (flush) begin
      state     <= INIT;
      sweep_idx <= '0;
    end else if (state == INIT) begin
      sweep_idx <= sweep_idx + 1'b1;
      if (&sweep_idx) state <= RUN;
    end
  end

  assign ready = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_vld <= 1'b0;
      lk_tag <= '0;
    end else begin
      lk_vld <= lookup_en & (state == RUN);
      lk_tag <= lookup_pc[PC_W-1:IDX_W];
    end
  end

  assign rd_a        = entry_t'(ra_raw);
  assign pred_hit    = lk_vld & rd_a.valid & (rd_a.tag == lk_tag);
  assign pred_taken  = pred_hit & rd_a.ctr[CTR_W-1];
  assign pred_target = pred_hit ? rd_a.target : '0;

  // Update path: the async port reads this cycle's entry and the result is written at the
  // edge, so an update in the next cycle already sees it (back-to-back forwarding).
  assign upd_idx = upd_pc[IDX_W-1:0];
  assign upd_tag = upd_pc[PC_W-1:IDX_W];
  assign rd_b    = entry_t'(rb_raw);
  assign upd_hit = rd_b.valid & (rd_b.tag == upd_tag);

  always_comb begin
    nxt    = rd_b;
    upd_we = 1'b0;
    if (upd_valid && state == RUN) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (upd_taken) begin
          nxt.ctr    = CTR_W'(sat_inc(32'(rd_b.ctr), CTR_W));
          nxt.target = upd_target;
        end else if (rd_b.ctr == '0) begin
          nxt.valid = 1'b0;
        end else begin
          nxt.ctr = CTR_W'(sat_dec(32'(rd_b.ctr)));
        end
      end else if (upd_taken) begin
        upd_we     = 1'b1;
        nxt.tag    = upd_tag;
        nxt.valid  = 1'b1;
        nxt.ctr    = CTR_W'(1) << (CTR_W - 1);
        nxt.target = upd_target;
      end
    end
  end

  assign we    = (state == INIT) | upd_we;
  assign waddr = (state == INIT) ? sweep_idx : upd_idx;
  assign wdata = (state == INIT) ? '0 : ENT_W'(nxt);

  btb_ram #(.AW(IDX_W), .W(ENT_W)) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .ra_addr (lookup_pc[IDX_W-1:0]),
    .ra_data (ra_raw),
    .rb_addr (upd_idx),
    .rb_data (rb_raw)
  );

  assign upd_mispredict = upd_valid &
    ((upd_taken != upd_pred_taken) |
     (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt      <= '0;
      hit_cnt     <= '0;
      mispred_cnt <= '0;
    end else begin
      if (upd_valid && state == RUN) br_cnt <= sat_inc(br_cnt, 32);
      if (pred_hit)                  hit_cnt <= sat_inc(hit_cnt, 32);
      if (upd_mispredict)            mispred_cnt <= sat_inc(mispred_cnt, 32);
    end
  end
`else
  assign br_cnt      = '0;
  assign hit_cnt     = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_btb_param.sv
// Randomized + directed bench for btb_param against an array-based behavioural model.
module tb_btb_param;
  localparam int N = 512;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, lookup_en = 1'b0;
  logic [15:0] lookup_pc = '0;
  logic        pred_hit, pred_taken, ready, upd_mispredict;
  logic [15:0] pred_target;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
  logic [15:0] upd_pc = '0, upd_target = '0, upd_pred_target = '0;
  logic [31:0] br_cnt, hit_cnt, mispred_cnt;

  btb_param #(.PC_W(16), .IDX_W(9), .CTR_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target), .ready(ready),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .upd_mispredict(upd_mispredict), .br_cnt(br_cnt), .hit_cnt(hit_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: plain arrays indexed by pc % N, tag = pc / N.
  bit          m_v[N];
  int          m_tag[N], m_ctr[N], m_tgt[N];
  bit          m_run;
  int          m_idx;
  bit          e_hit, e_taken;
  logic [15:0] e_tgt;
  logic [31:0] e_br, e_hitc, e_mis;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mis_f();
    if (!upd_valid) return 1'b0;
    if (upd_taken != upd_pred_taken) return 1'b1;
    return upd_taken && (upd_target != upd_pred_target);
  endfunction

  function automatic logic [31:0] bump(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  task automatic model_step();
    int i, t;
    if (e_hit) e_hitc = bump(e_hitc);
    if (mis_f()) e_mis = bump(e_mis);
    if (m_run && upd_valid) e_br = bump(e_br);
    e_hit = 1'b0; e_taken = 1'b0; e_tgt = '0;
    if (lookup_en && m_run) begin
      i = int'(lookup_pc) % N; t = int'(lookup_pc) / N;
      e_hit   = m_v[i] && (m_tag[i] == t);
      e_taken = e_hit && (m_ctr[i] >= 2);
      e_tgt   = e_hit ? 16'(m_tgt[i]) : 16'h0;
    end
    if (m_run && upd_valid) begin
      i = int'(upd_pc) % N; t = int'(upd_pc) / N;
      if (m_v[i] && m_tag[i] == t) begin
        if (upd_taken) begin
          if (m_ctr[i] < 3) m_ctr[i]++;
          m_tgt[i] = int'(upd_target);
        end else if (m_ctr[i] == 0) m_v[i] = 1'b0;
        else m_ctr[i]--;
      end else if (upd_taken) begin
        m_v[i] = 1'b1; m_tag[i] = t; m_ctr[i] = 2; m_tgt[i] = int'(upd_target);
      end
    end
    if (!m_run) m_v[m_idx] = 1'b0;
    if (flush) begin
      m_run = 1'b0; m_idx = 0;
    end else if (!m_run) begin
      m_idx++;
      if (m_idx == N) m_run = 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0; m_idx = 0; e_hit = 1'b0; e_taken = 1'b0; e_tgt = '0;
      e_br = '0; e_hitc = '0; e_mis = '0;
    end else model_step();
  end

  // Single compare process: every cycle, mid-period.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pred_hit",    32'(pred_hit),       32'(e_hit));
      chk("pred_taken",  32'(pred_taken),     32'(e_taken));
      chk("pred_target", 32'(pred_target),    32'(e_tgt));
      chk("ready",       32'(ready),          32'(m_run));
      chk("mispredict",  32'(upd_mispredict), 32'(mis_f()));
`ifdef BTB_STATS_EN
      chk("br_cnt", br_cnt, e_br);
      chk("hit_cnt", hit_cnt, e_hitc);
      chk("mispred_cnt", mispred_cnt, e_mis);
`else
      chk("br_cnt", br_cnt, 32'h0);
      chk("hit_cnt", hit_cnt, 32'h0);
      chk("mispred_cnt", mispred_cnt, 32'h0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    flush = 1'b0; lookup_en = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
    upd_pred_taken = 1'b0;
  endtask

  task automatic do_upd(input logic [15:0] pc, input bit tk, input logic [15:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = tk; upd_pred_target = tgt;
    cyc();
    upd_valid = 1'b0;
  endtask

  task automatic do_look(input logic [15:0] pc);
    lookup_en = 1'b1; lookup_pc = pc;
    cyc();
    lookup_en = 1'b0;
  endtask

  function automatic logic [15:0] pick_pc();
    return 16'($urandom_range(0, 3) * N + $urandom_range(0, 7));
  endfunction

  task automatic rnd_drive(input bit allow_flush);
    lookup_en       = ($urandom_range(0, 3) != 0);
    lookup_pc       = pick_pc();
    upd_valid       = 1'($urandom_range(0, 1));
    upd_pc          = pick_pc();
    upd_taken       = ($urandom_range(0, 2) != 0);
    upd_target      = 16'($urandom);
    upd_pred_taken  = 1'($urandom);
    upd_pred_target = ($urandom_range(0, 1) != 0) ? upd_target : 16'($urandom);
    flush           = allow_flush && ($urandom_range(0, 399) == 0);
  endtask

  initial begin
    int n0, hits, w;
    idle();
    rst = 1'b1; lookup_en = 1'b1; lookup_pc = 16'h0204;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit",    32'(pred_hit),    32'h0);
    chk("rst_taken",  32'(pred_taken),  32'h0);
    chk("rst_target", 32'(pred_target), 32'h0);
    chk("rst_ready",  32'(ready),       32'h0);
    chk("rst_mispred_cnt", mispred_cnt, 32'h0);
    rst = 1'b0; chk_en = 1'b1;

    // Init sweep: ready and hits stay low for 512 cycles, ready rises on the 513th.
    n0 = 0;
    for (int k = 1; k <= 511; k++) begin
      cyc();
      if (!ready && !pred_hit) n0++;
    end
    chk("init_low_cycles", 32'(n0), 32'd511);
    cyc();
    chk("init_ready_up", 32'(ready), 32'h1);
    idle();

    do_upd(16'h0204, 1'b1, 16'h0300);
    do_look(16'h0204);
    chk("alloc_hit",    32'(pred_hit),    32'h1);
    chk("alloc_taken",  32'(pred_taken),  32'h1);
    chk("alloc_target", 32'(pred_target), 32'h0300);

    repeat (3) do_upd(16'h0204, 1'b0, 16'h0300);
    do_look(16'h0204);
    chk("decay_invalid_hit", 32'(pred_hit), 32'h0);

    do_upd(16'h0204, 1'b1, 16'h0300);
    do_upd(16'h0404, 1'b1, 16'h0500);
    do_look(16'h0204);
    chk("alias_old_miss", 32'(pred_hit), 32'h0);
    do_look(16'h0404);
    chk("alias_new_hit",    32'(pred_hit),    32'h1);
    chk("alias_new_target", 32'(pred_target), 32'h0500);

    // Same-index lookup and update: lookup sees pre-update data.
    lookup_en = 1'b1; lookup_pc = 16'h0404;
    upd_valid = 1'b1; upd_pc = 16'h0404; upd_taken = 1'b0; upd_target = 16'h0;
    upd_pred_taken = 1'b0; upd_pred_target = 16'h0;
    cyc();
    idle();
    chk("same_cyc_taken",  32'(pred_taken),  32'h1);
    chk("same_cyc_target", 32'(pred_target), 32'h0500);
    do_look(16'h0404);
    chk("after_dec_hit",   32'(pred_hit),   32'h1);
    chk("after_dec_taken", 32'(pred_taken), 32'h0);

    upd_valid = 1'b1; upd_pc = 16'h0604; upd_taken = 1'b1; upd_target = 16'h0300;
    upd_pred_taken = 1'b1; upd_pred_target = 16'h0300;
    #1 chk("mispred_none", 32'(upd_mispredict), 32'h0);
    upd_pred_target = 16'h0310;
    #1 chk("mispred_target", 32'(upd_mispredict), 32'h1);
    upd_taken = 1'b0;
    #1 chk("mispred_dir", 32'(upd_mispredict), 32'h1);
    upd_taken = 1'b1;
    cyc();
    idle();

    repeat (3000) begin
      rnd_drive(1'b1);
      cyc();
    end
    idle();
    w = 0;
    while (!ready && w < 600) begin
      cyc();
      w++;
    end
    chk("ready_after_random", 32'(ready), 32'h1);

    // Flush then hammer lookups/taken updates through the whole sweep.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    hits = 0;
    repeat (512) begin
      rnd_drive(1'b0);
      upd_taken = 1'b1;
      cyc();
      if (pred_hit) hits++;
    end
    idle();
    cyc();
    chk("sweep_hits", 32'(hits), 32'h0);
    chk("sweep_ready", 32'(ready), 32'h1);
    hits = 0;
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 8; i++) begin
        do_look(16'(t * N + i));
        if (pred_hit) hits++;
      end
    chk("post_flush_all_invalid", 32'(hits), 32'h0);

    chk_en = 1'b0;
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
